// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
// dmem_ctrl: data-memory responder between the load/store buffer and the
// memory arbiter. It takes one request at a time, runs it as byte-serial
// accesses on the 8-bit RAM port, acknowledges with a one-cycle done pulse
// and broadcasts load results on the data CDB with the requesting ROB tag.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable, low freezes every register
//   jp_wrong          misprediction flush (aborts loads, not stores)
//   req_*             request valid/address/store data/opcode/ROB tag
//   done              one-cycle acknowledge
//   cdb_sgn/result/rob load result broadcast
//   mem_din/dout/a/wr shared 8-bit RAM port (mem_din arrives one cycle
//                     after its address)
//   io_buffer_full    UART output buffer full
//
// Build option: define DMEM_IO_STALL_EN to hold off stores into the IO
// range (addr[17:16] == 2'b11) while io_buffer_full is high. Without it
// io_buffer_full is ignored.
module dmem_ctrl #(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jp_wrong,
    input  logic             req_sgn,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_val,
    input  logic [5:0]       req_opcode,
    input  logic [ROB_W-1:0] req_rob,
    output logic             done,
    output logic             cdb_sgn,
    output logic [31:0]      cdb_result,
    output logic [ROB_W-1:0] cdb_rob,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full
);
    localparam logic [5:0] OP_LB  = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LW  = 6'd13;
    localparam logic [5:0] OP_LBU = 6'd14;
    localparam logic [5:0] OP_LHU = 6'd15;
    localparam logic [5:0] OP_SB  = 6'd16;
    localparam logic [5:0] OP_SH  = 6'd17;
    localparam logic [5:0] OP_SW  = 6'd18;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic [31:0]      addr_q, addr_n, val_q, val_n, data_q, data_n;
    logic [5:0]       op_q, op_n;
    logic [ROB_W-1:0] rob_q, rob_n;
    logic             done_n, cdb_sgn_n, mem_wr_n;
    logic [31:0]      cdb_result_n, mem_a_n;
    logic [ROB_W-1:0] cdb_rob_n;
    logic [7:0]       mem_dout_n;
    logic [2:0]       nbytes;
    logic [1:0]       lane;
    logic             io_block, stall_acc, stall_busy;

    // Bytes moved by an opcode; 0 marks an unknown opcode.
    function automatic logic [2:0] byte_count(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [7:0] byte_lane(input logic [31:0] v, input logic [1:0] k);
        return v[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   return 32'($signed(d[7:0]));
            OP_LH:   return 32'($signed(d[15:0]));
            OP_LBU:  return {24'd0, d[7:0]};
            OP_LHU:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

`ifdef DMEM_IO_STALL_EN
    assign io_block = io_buffer_full;
`else
    assign io_block = io_buffer_full & 1'b0;
`endif
    assign stall_acc  = io_block && (req_addr[17:16] == 2'b11);
    assign stall_busy = io_block && (addr_q[17:16] == 2'b11);

    // Stores: cnt counts bytes already put on the port. Loads: cnt is the
    // number of edges spent in BUSY, so at each edge with cnt=k>0 mem_din
    // holds byte k-1 (the address presented in the previous cycle).
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        addr_n       = addr_q;
        val_n        = val_q;
        op_n         = op_q;
        rob_n        = rob_q;
        data_n       = data_q;
        done_n       = 1'b0;
        cdb_sgn_n    = 1'b0;
        cdb_result_n = cdb_result;
        cdb_rob_n    = cdb_rob;
        mem_a_n      = mem_a;
        mem_dout_n   = mem_dout;
        mem_wr_n     = 1'b0;
        nbytes       = byte_count(op_q);
        lane         = cnt[1:0] - 2'd1;
        case (state)
            IDLE: begin
                if (req_sgn && !jp_wrong) begin
                    op_n = req_opcode;
                    if (byte_count(req_opcode) == 3'd0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        addr_n  = req_addr;
                        val_n   = req_val;
                        rob_n   = req_rob;
                        state_n = BUSY;
                        cnt_n   = 3'd0;
                        if (!is_store(req_opcode)) begin
                            mem_a_n = req_addr;
                        end else if (!stall_acc) begin
                            mem_a_n    = req_addr;
                            mem_dout_n = req_val[7:0];
                            mem_wr_n   = 1'b1;
                            cnt_n      = 3'd1;
                        end
                    end
                end
            end
            BUSY: begin
                if (is_store(op_q)) begin
                    if (cnt == nbytes) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (!stall_busy) begin
                        mem_a_n    = addr_q + {29'd0, cnt};
                        mem_dout_n = byte_lane(val_q, cnt[1:0]);
                        mem_wr_n   = 1'b1;
                        cnt_n      = cnt + 3'd1;
                    end
                end else if (jp_wrong) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    if (cnt != 3'd0) begin
                        data_n[{lane, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt == nbytes) begin
                        state_n      = DONE;
                        done_n       = 1'b1;
                        cdb_sgn_n    = 1'b1;
                        cdb_result_n = extend_load(op_q, data_n);
                        cdb_rob_n    = rob_q;
                    end else begin
                        cnt_n = cnt + 3'd1;
                        if ((cnt + 3'd1) < nbytes) begin
                            mem_a_n = addr_q + {29'd0, cnt} + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            done       <= 1'b0;
            cdb_sgn    <= 1'b0;
            mem_wr     <= 1'b0;
            cdb_result <= 32'd0;
            cdb_rob    <= '0;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
        end else if (rdy) begin
            state      <= state_n;
            cnt        <= cnt_n;
            done       <= done_n;
            cdb_sgn    <= cdb_sgn_n;
            mem_wr     <= mem_wr_n;
            cdb_result <= cdb_result_n;
            cdb_rob    <= cdb_rob_n;
            mem_a      <= mem_a_n;
            mem_dout   <= mem_dout_n;
        end
    end

    // Request latches and load assembly carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (rdy) begin
            addr_q <= addr_n;
            val_q  <= val_n;
            op_q   <= op_n;
            rob_q  <= rob_n;
            data_q <= data_n;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, jp_wrong, req_sgn, io_buffer_full;
    logic [31:0] req_addr, req_val;
    logic [5:0]  req_opcode;
    logic [3:0]  req_rob;
    logic        done, cdb_sgn, mem_wr;
    logic [31:0] cdb_result, mem_a;
    logic [3:0]  cdb_rob;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;

    dmem_ctrl #(.ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
        .req_sgn(req_sgn), .req_addr(req_addr), .req_val(req_val),
        .req_opcode(req_opcode), .req_rob(req_rob),
        .done(done), .cdb_sgn(cdb_sgn), .cdb_result(cdb_result), .cdb_rob(cdb_rob),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DMEM_IO_STALL_EN
    localparam int IO_EXTRA = 3;
`else
    localparam int IO_EXTRA = 0;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_load;
        logic [31:0] res;
        logic [3:0]  rob;
        int          t0;
        int          lat;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t sb_q[$];
    wr_t  wq[$];
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] last_result = 32'd0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction
    function automatic int nbytes(input logic [5:0] op);
        case (op)
            6'd11, 6'd14, 6'd16: return 1;
            6'd12, 6'd15, 6'd17: return 2;
            6'd13, 6'd18:        return 4;
            default:             return 0;
        endcase
    endfunction

    // RAM device: synchronous read, write on mem_wr, both held by rdy.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram_rd(mem_a);
            if (mem_wr) ram[mem_a] = mem_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected writes, response and latency for one request.
    function automatic void push_exp(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [31:0] val, input logic [3:0] rob,
                                     input int t0, input int extra);
        exp_t e;
        wr_t w;
        logic [31:0] word;
        int n;
        n = nbytes(op);
        e.is_load = 1'b0; e.res = 32'd0; e.rob = rob; e.t0 = t0;
        if (n == 0) begin
            e.lat = 1 + extra;
        end else if (op >= 6'd16) begin
            for (int k = 0; k < n; k++) begin
                w.a = addr + 32'(k);
                w.d = 8'(val >> (8 * k));
                wq.push_back(w);
                ref_mem[w.a] = w.d;
            end
            e.lat = n + 1 + extra;
        end else begin
            word = 32'd0;
            for (int k = 0; k < n; k++)
                word = word + (32'(ref_rd(addr + 32'(k))) << (8 * k));
            if (op == 6'd11 && word >= 32'd128)   word = word - 32'd256;
            if (op == 6'd12 && word >= 32'd32768) word = word - 32'd65536;
            e.is_load = 1'b1;
            e.res = word;
            e.lat = n + 2 + extra;
        end
        sb_q.push_back(e);
    endfunction

    // Monitor: pops expectations whenever the DUT writes or acknowledges.
    exp_t me;
    wr_t  mw;
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%02h, none expected", mem_a, mem_dout);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", mem_a, mw.a);
                    chk("wr_data", 32'(mem_dout), 32'(mw.d));
                end
            end
            if (cdb_sgn && !done) begin
                checks++; failures++;
                $display("FAIL cdb_without_done: cdb_sgn=1 done=0 required done=1");
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: done=1 cdb_sgn=%0d, none expected", cdb_sgn);
                end else begin
                    me = sb_q.pop_front();
                    chk("latency", 32'(cyc - me.t0), 32'(me.lat));
                    chk("cdb_sgn", 32'(cdb_sgn), 32'(me.is_load));
                    if (me.is_load) begin
                        chk("cdb_result", cdb_result, me.res);
                        chk("cdb_rob", 32'(cdb_rob), 32'(me.rob));
                        last_result = cdb_result;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] val,
                         input logic [3:0] rob, input bit expect_it);
        req_opcode = op; req_addr = addr; req_val = val; req_rob = rob; req_sgn = 1'b1;
        if (expect_it) push_exp(op, addr, val, rob, cyc, 0);
        @(posedge clk); #1;
        req_sgn = 1'b0;
    endtask

    task automatic wait_drain(input bit noise);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || wq.size() != 0) && n < 200) begin
            jp_wrong = noise ? 1'($urandom_range(0, 1)) : 1'b0;
`ifndef DMEM_IO_STALL_EN
            io_buffer_full = 1'($urandom_range(0, 1));
`endif
            @(posedge clk); #1;
            n++;
        end
        jp_wrong = 1'b0;
        io_buffer_full = 1'b0;
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL drain_timeout: %0d responses and %0d writes outstanding, required 0", sb_q.size(), wq.size());
            sb_q.delete();
            wq.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cdb_sgn"}, 32'(cdb_sgn), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_cdb_result"}, cdb_result, 32'd0);
        chk({tag, "_cdb_rob"}, 32'(cdb_rob), 32'd0);
        chk({tag, "_mem_a"}, mem_a, 32'd0);
        chk({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    endtask

    logic [5:0]  ops [10] = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd0, 6'd33};
    logic [5:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] snap_a;
    logic [7:0]  snap_d;
    logic        snap_wr;

    initial begin
        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; req_sgn = 1'b0; io_buffer_full = 1'b0;
        req_addr = 32'd0; req_val = 32'd0; req_opcode = 6'd0; req_rob = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_init");
        rst = 1'b0;
        idle_cycles(1);

        issue(6'd18, 32'h100, 32'hDEADBEEF, 4'd3, 1'b1); wait_drain(1'b0);
        issue(6'd16, 32'h100, 32'h00000080, 4'd5, 1'b1); wait_drain(1'b0);
        issue(6'd11, 32'h100, 32'd0, 4'd7, 1'b1); wait_drain(1'b0);
        chk("lb_value", last_result, 32'hFFFFFF80);
        issue(6'd14, 32'h100, 32'd0, 4'd8, 1'b1); wait_drain(1'b0);
        chk("lbu_value", last_result, 32'h00000080);
        issue(6'd12, 32'h102, 32'd0, 4'd9, 1'b1); wait_drain(1'b0);
        chk("lh_value", last_result, 32'hFFFFDEAD);
        issue(6'd13, 32'hFFFFFFFF, 32'd0, 4'd10, 1'b1); wait_drain(1'b0);
        issue(6'd0, 32'h100, 32'd0, 4'd1, 1'b1); wait_drain(1'b0);

        // Flush during an LW: no response, then an SB right after.
        issue(6'd13, 32'h100, 32'd0, 4'd2, 1'b0);
        jp_wrong = 1'b1;
        idle_cycles(1);
        jp_wrong = 1'b0;
        issue(6'd16, 32'h104, 32'h3C, 4'd4, 1'b1); wait_drain(1'b0);
        idle_cycles(6);

        // Request presented together with a flush is dropped.
        req_opcode = 6'd18; req_addr = 32'h180; req_val = 32'h11223344; req_rob = 4'd6;
        req_sgn = 1'b1; jp_wrong = 1'b1;
        idle_cycles(1);
        req_sgn = 1'b0; jp_wrong = 1'b0;
        idle_cycles(8);

        // IO-range SB with the UART buffer full for three cycles.
        req_opcode = 6'd16; req_addr = 32'h30000; req_val = 32'h5A; req_rob = 4'd1;
        req_sgn = 1'b1; io_buffer_full = 1'b1;
        push_exp(6'd16, 32'h30000, 32'h5A, 4'd1, cyc, IO_EXTRA);
        idle_cycles(1);
        req_sgn = 1'b0;
        idle_cycles(2);
        io_buffer_full = 1'b0;
        wait_drain(1'b0);

        // rdy low for two cycles in the middle of an SH.
        req_opcode = 6'd17; req_addr = 32'h120; req_val = 32'h1234; req_rob = 4'd2;
        req_sgn = 1'b1;
        push_exp(6'd17, 32'h120, 32'h1234, 4'd2, cyc, 2);
        idle_cycles(1);
        req_sgn = 1'b0; rdy = 1'b0;
        snap_a = mem_a; snap_d = mem_dout; snap_wr = mem_wr;
        chk("rdy_first_byte_wr", 32'(mem_wr), 32'd1);
        idle_cycles(1);
        chk("rdy_freeze_a1", mem_a, snap_a);
        chk("rdy_freeze_wr1", 32'(mem_wr), 32'(snap_wr));
        idle_cycles(1);
        chk("rdy_freeze_a2", mem_a, snap_a);
        chk("rdy_freeze_d2", 32'(mem_dout), 32'(snap_d));
        chk("rdy_freeze_done2", 32'(done), 32'd0);
        rdy = 1'b1;
        wait_drain(1'b0);

        // Reset in the middle of an LW.
        issue(6'd13, 32'h140, 32'd0, 4'd6, 1'b0);
        rst = 1'b1;
        idle_cycles(1);
        reset_checks("rst_mid");
        rst = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 150; i++) begin
            r_op = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0:       r_addr = 32'h30000 + 32'($urandom_range(0, 7));
                1:       r_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                default: r_addr = 32'h100 + 32'($urandom_range(0, 15));
            endcase
            issue(r_op, r_addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            wait_drain(r_op >= 6'd16 && r_op <= 6'd18);
        end
        idle_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
